// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared constants and helpers for the ID/EX stage buffer.
//   - default field widths (OPC_W_DEF .. DATA_W_DEF)
//   - id_ex_payload_w(): total width of the flat held-entry payload
//   - id_ex_off_*(): bit offsets of each field inside that payload
//   - OFF_*_DEF: the same offsets evaluated at the default widths
// Payload layout, MSB to LSB:
//   {wr_en, opcode, operanda, operandb, dmaddr, dest, opAdata, opBdata}
package id_ex_pkg;

    localparam int OPC_W_DEF  = 4;
    localparam int REG_W_DEF  = 3;
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    function automatic int id_ex_payload_w(input int opc_w, input int reg_w,
                                           input int addr_w, input int data_w);
        return 1 + opc_w + 3 * reg_w + addr_w + 2 * data_w;
    endfunction

    function automatic int id_ex_off_opb(input int data_w);
        return 0 * data_w;
    endfunction

    function automatic int id_ex_off_opa(input int data_w);
        return data_w;
    endfunction

    function automatic int id_ex_off_dest(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int id_ex_off_addr(input int reg_w, input int data_w);
        return 2 * data_w + reg_w;
    endfunction

    function automatic int id_ex_off_oprb(input int reg_w, input int addr_w,
                                          input int data_w);
        return 2 * data_w + reg_w + addr_w;
    endfunction

    function automatic int id_ex_off_opra(input int reg_w, input int addr_w,
                                          input int data_w);
        return 2 * data_w + 2 * reg_w + addr_w;
    endfunction

    function automatic int id_ex_off_opc(input int reg_w, input int addr_w,
                                         input int data_w);
        return 2 * data_w + 3 * reg_w + addr_w;
    endfunction

    function automatic int id_ex_off_wr(input int opc_w, input int reg_w,
                                        input int addr_w, input int data_w);
        return 2 * data_w + 3 * reg_w + addr_w + opc_w;
    endfunction

    localparam int OFF_OPB_DEF  = id_ex_off_opb(DATA_W_DEF);
    localparam int OFF_OPA_DEF  = id_ex_off_opa(DATA_W_DEF);
    localparam int OFF_DEST_DEF = id_ex_off_dest(DATA_W_DEF);
    localparam int OFF_ADDR_DEF = id_ex_off_addr(REG_W_DEF, DATA_W_DEF);
    localparam int OFF_OPRB_DEF = id_ex_off_oprb(REG_W_DEF, ADDR_W_DEF, DATA_W_DEF);
    localparam int OFF_OPRA_DEF = id_ex_off_opra(REG_W_DEF, ADDR_W_DEF, DATA_W_DEF);
    localparam int OFF_OPC_DEF  = id_ex_off_opc(REG_W_DEF, ADDR_W_DEF, DATA_W_DEF);
    localparam int OFF_WR_DEF   = id_ex_off_wr(OPC_W_DEF, REG_W_DEF, ADDR_W_DEF, DATA_W_DEF);

endpackage

// File: rtl/id_ex_hist_shift.sv
// id_ex_hist_shift: HIST_DEPTH-slot shift register with per-slot valid.
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset (clears valid and data)
//   shift_i  in   advance: slot 0 <= ent_i, slot k <= slot k-1, oldest dropped
//   ent_i    in   ENT_W  entry written into slot 0 on shift
//   vld_o    out  HIST_DEPTH  per-slot valid, bit 0 is the newest slot
//   ent_o    out  HIST_DEPTH*ENT_W  slot k at [k*ENT_W +: ENT_W]
module id_ex_hist_shift #(
    parameter int HIST_DEPTH = 2,
    parameter int ENT_W      = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        shift_i,
    input  logic [ENT_W-1:0]            ent_i,
    output logic [HIST_DEPTH-1:0]       vld_o,
    output logic [HIST_DEPTH*ENT_W-1:0] ent_o
);

    logic [HIST_DEPTH-1:0] vld_q, vld_d;
    logic [ENT_W-1:0]      ent_q [HIST_DEPTH];
    logic [ENT_W-1:0]      ent_d [HIST_DEPTH];

    always_comb begin
        vld_d = vld_q;
        for (int k = 0; k < HIST_DEPTH; k++) begin
            ent_d[k] = ent_q[k];
        end
        if (shift_i) begin
            vld_d[0] = 1'b1;
            ent_d[0] = ent_i;
            for (int k = 1; k < HIST_DEPTH; k++) begin
                vld_d[k] = vld_q[k-1];
                ent_d[k] = ent_q[k-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int k = 0; k < HIST_DEPTH; k++) begin
                ent_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < HIST_DEPTH; k++) begin
                ent_q[k] <= ent_d[k];
            end
        end
    end

    assign vld_o = vld_q;

    for (genvar k = 0; k < HIST_DEPTH; k++) begin : g_flat
        assign ent_o[k*ENT_W +: ENT_W] = ent_q[k];
    end

endmodule

// File: rtl/id_ex_stage_buf.sv
// id_ex_stage_buf: one-entry ID/EX pipeline buffer with flush, a retirement
// history of the last HIST_DEPTH instructions taken by execute, and
// combinational RAW hazard flags for the instruction decode is offering.
//   clk, rst_n                 clock / asynchronous active-low reset
//   in_valid / in_ready        decode-side handshake
//   in_*                       decoded fields of the offered instruction
//   flush                      squash held entry and block incoming transfer
//   out_valid / out_ready      execute-side handshake
//   out_*                      held entry fields
//   hist_valid/dest/opcode/wr_en  history slots, slot 0 newest
//   haz_a, haz_b               RAW hazard on in_operanda / in_operandb
// Handshake: a transfer happens on an edge where valid & ready are both 1;
// a valid source holds its payload stable until that edge; ready may depend
// combinationally on the sink's downstream ready (out_ready -> in_ready).
module id_ex_stage_buf
    import id_ex_pkg::*;
#(
    parameter int OPC_W      = OPC_W_DEF,
    parameter int REG_W      = REG_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int HIST_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_wr_en,
    input  logic [OPC_W-1:0]             in_opcode,
    input  logic [REG_W-1:0]             in_operanda,
    input  logic [REG_W-1:0]             in_operandb,
    input  logic [ADDR_W-1:0]            in_dmaddr,
    input  logic [REG_W-1:0]             in_dest,
    input  logic [DATA_W-1:0]            in_opAdata,
    input  logic [DATA_W-1:0]            in_opBdata,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_wr_en,
    output logic [OPC_W-1:0]             out_opcode,
    output logic [REG_W-1:0]             out_operanda,
    output logic [REG_W-1:0]             out_operandb,
    output logic [ADDR_W-1:0]            out_dmaddr,
    output logic [REG_W-1:0]             out_dest,
    output logic [DATA_W-1:0]            out_opAdata,
    output logic [DATA_W-1:0]            out_opBdata,
    output logic [HIST_DEPTH-1:0]        hist_valid,
    output logic [HIST_DEPTH*REG_W-1:0]  hist_dest,
    output logic [HIST_DEPTH*OPC_W-1:0]  hist_opcode,
    output logic [HIST_DEPTH-1:0]        hist_wr_en,
    output logic                         haz_a,
    output logic                         haz_b
);

    localparam int PAY_W  = id_ex_payload_w(OPC_W, REG_W, ADDR_W, DATA_W);
    localparam int O_OPB  = id_ex_off_opb(DATA_W);
    localparam int O_OPA  = id_ex_off_opa(DATA_W);
    localparam int O_DEST = id_ex_off_dest(DATA_W);
    localparam int O_ADDR = id_ex_off_addr(REG_W, DATA_W);
    localparam int O_OPRB = id_ex_off_oprb(REG_W, ADDR_W, DATA_W);
    localparam int O_OPRA = id_ex_off_opra(REG_W, ADDR_W, DATA_W);
    localparam int O_OPC  = id_ex_off_opc(REG_W, ADDR_W, DATA_W);
    localparam int O_WR   = id_ex_off_wr(OPC_W, REG_W, ADDR_W, DATA_W);
    // History keeps only what hazard detection and debug need.
    localparam int ENT_W  = 1 + OPC_W + REG_W;

    logic             valid_q, valid_d;
    logic [PAY_W-1:0] pay_q, pay_d;
    logic [PAY_W-1:0] in_pay;
    logic             in_fire, out_fire;

    assign in_pay = {in_wr_en, in_opcode, in_operanda, in_operandb,
                     in_dmaddr, in_dest, in_opAdata, in_opBdata};

    assign in_ready = ~flush & (~valid_q | out_ready);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = valid_q & out_ready;

    // Payload only changes on a load, so a stall or a drop leaves every
    // out_* field bit-stable. Flush without a retire drops the entry; with
    // a retire the entry leaves normally, and in_ready is already 0.
    always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        if (in_fire) begin
            valid_d = 1'b1;
            pay_d   = in_pay;
        end else if (out_fire || flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_wr_en    = pay_q[O_WR];
    assign out_opcode   = pay_q[O_OPC  +: OPC_W];
    assign out_operanda = pay_q[O_OPRA +: REG_W];
    assign out_operandb = pay_q[O_OPRB +: REG_W];
    assign out_dmaddr   = pay_q[O_ADDR +: ADDR_W];
    assign out_dest     = pay_q[O_DEST +: REG_W];
    assign out_opAdata  = pay_q[O_OPA  +: DATA_W];
    assign out_opBdata  = pay_q[O_OPB  +: DATA_W];

    // History advances only when execute takes the held entry.
    logic [ENT_W-1:0]            hist_in;
    logic [HIST_DEPTH*ENT_W-1:0] hist_flat;

    assign hist_in = {out_wr_en, out_opcode, out_dest};

    id_ex_hist_shift #(
        .HIST_DEPTH (HIST_DEPTH),
        .ENT_W      (ENT_W)
    ) u_hist (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .shift_i (out_fire),
        .ent_i   (hist_in),
        .vld_o   (hist_valid),
        .ent_o   (hist_flat)
    );

    for (genvar k = 0; k < HIST_DEPTH; k++) begin : g_hist_out
        assign hist_dest[k*REG_W +: REG_W]   = hist_flat[k*ENT_W +: REG_W];
        assign hist_opcode[k*OPC_W +: OPC_W] = hist_flat[k*ENT_W + REG_W +: OPC_W];
        assign hist_wr_en[k]                 = hist_flat[k*ENT_W + ENT_W - 1];
    end

    // Hazard candidates: index 0 is the held entry, index k+1 is history
    // slot k. A candidate counts only if it is valid and writes a register.
    logic [HIST_DEPTH:0] cand_ok;
    logic [REG_W-1:0]    cand_dest [HIST_DEPTH+1];
    logic [HIST_DEPTH:0] match_a, match_b;

    assign cand_ok[0]   = valid_q & out_wr_en;
    assign cand_dest[0] = out_dest;

    for (genvar k = 0; k < HIST_DEPTH; k++) begin : g_cand
        assign cand_ok[k+1]   = hist_valid[k] & hist_wr_en[k];
        assign cand_dest[k+1] = hist_dest[k*REG_W +: REG_W];
    end

    for (genvar k = 0; k <= HIST_DEPTH; k++) begin : g_haz
        assign match_a[k] = cand_ok[k] & (cand_dest[k] == in_operanda);
        assign match_b[k] = cand_ok[k] & (cand_dest[k] == in_operandb);
    end

    assign haz_a = in_valid & (|match_a);
    assign haz_b = in_valid & (|match_b);

endmodule

// File: tb/tb_id_ex_stage_buf.sv
module tb_id_ex_stage_buf;

    localparam int HD = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_wr_en, flush;
    logic [3:0]    in_opcode, in_dmaddr;
    logic [2:0]    in_operanda, in_operandb, in_dest;
    logic [7:0]    in_opAdata, in_opBdata;
    logic          out_valid, out_ready, out_wr_en;
    logic [3:0]    out_opcode, out_dmaddr;
    logic [2:0]    out_operanda, out_operandb, out_dest;
    logic [7:0]    out_opAdata, out_opBdata;
    logic [HD-1:0] hist_valid, hist_wr_en;
    logic [HD*3-1:0] hist_dest;
    logic [HD*4-1:0] hist_opcode;
    logic          haz_a, haz_b;

    int total = 0;
    int bad   = 0;

    id_ex_stage_buf #(.HIST_DEPTH(HD)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_wr_en(in_wr_en),
        .in_opcode(in_opcode), .in_operanda(in_operanda), .in_operandb(in_operandb),
        .in_dmaddr(in_dmaddr), .in_dest(in_dest),
        .in_opAdata(in_opAdata), .in_opBdata(in_opBdata),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_wr_en(out_wr_en),
        .out_opcode(out_opcode), .out_operanda(out_operanda), .out_operandb(out_operandb),
        .out_dmaddr(out_dmaddr), .out_dest(out_dest),
        .out_opAdata(out_opAdata), .out_opBdata(out_opBdata),
        .hist_valid(hist_valid), .hist_dest(hist_dest), .hist_opcode(hist_opcode),
        .hist_wr_en(hist_wr_en), .haz_a(haz_a), .haz_b(haz_b)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic       iv, ordy, fl, wr;
        logic [3:0] opc;
        logic [2:0] dest, opa, opb;
        logic [7:0] ad;
        logic       e_rdy, e_ha, e_hb, e_ov;
        logic [3:0] e_opc;
        logic [7:0] e_ad;
        logic [1:0] e_hv;
        logic [7:0] e_hopc;
    } vec_t;

    function automatic vec_t mk(
        input logic iv, input logic ordy, input logic fl, input logic wr,
        input logic [3:0] opc, input logic [2:0] dest, input logic [2:0] opa,
        input logic [2:0] opb, input logic [7:0] ad,
        input logic e_rdy, input logic e_ha, input logic e_hb, input logic e_ov,
        input logic [3:0] e_opc, input logic [7:0] e_ad, input logic [1:0] e_hv,
        input logic [7:0] e_hopc);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.wr = wr; v.opc = opc; v.dest = dest;
        v.opa = opa; v.opb = opb; v.ad = ad; v.e_rdy = e_rdy; v.e_ha = e_ha;
        v.e_hb = e_hb; v.e_ov = e_ov; v.e_opc = e_opc; v.e_ad = e_ad;
        v.e_hv = e_hv; v.e_hopc = e_hopc;
        return v;
    endfunction

    vec_t tbl [16];

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       wr;
        logic [3:0] opc;
        logic [2:0] ra, rb;
        logic [3:0] addr;
        logic [2:0] dest;
        logic [7:0] ad, bd;
    } ent_t;

    logic  m_valid;
    ent_t  m_held;
    ent_t  m_hist[$];   // index 0 = most recently retired

    function automatic ent_t cur_in();
        ent_t e;
        e.wr = in_wr_en; e.opc = in_opcode; e.ra = in_operanda; e.rb = in_operandb;
        e.addr = in_dmaddr; e.dest = in_dest; e.ad = in_opAdata; e.bd = in_opBdata;
        return e;
    endfunction

    function automatic logic model_haz(input logic [2:0] r);
        logic h;
        h = m_valid && m_held.wr && (m_held.dest == r);
        foreach (m_hist[i]) begin
            if (m_hist[i].wr && m_hist[i].dest == r) h = 1'b1;
        end
        return in_valid && h;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_held  = '0;
        m_hist.delete();
    endtask

    task automatic model_edge();
        logic rdy, ifire, ofire;
        rdy   = !flush && (!m_valid || out_ready);
        ifire = in_valid && rdy;
        ofire = m_valid && out_ready;
        if (ofire) begin
            m_hist.push_front(m_held);
            if (m_hist.size() > HD) void'(m_hist.pop_back());
        end
        if (ifire) begin
            m_held  = cur_in();
            m_valid = 1'b1;
        end else if (ofire || flush) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic model_compare();
        logic [HD-1:0]   e_hv;
        logic [HD*3-1:0] e_hd;
        logic [HD*4-1:0] e_ho;
        logic [HD-1:0]   e_hw;
        e_hv = '0; e_hd = '0; e_ho = '0; e_hw = '0;
        for (int k = 0; k < m_hist.size(); k++) begin
            e_hv[k]        = 1'b1;
            e_hd[k*3 +: 3] = m_hist[k].dest;
            e_ho[k*4 +: 4] = m_hist[k].opc;
            e_hw[k]        = m_hist[k].wr;
        end
        check("rnd in_ready", 32'(in_ready), 32'(!flush && (!m_valid || out_ready)));
        check("rnd haz_a", 32'(haz_a), 32'(model_haz(in_operanda)));
        check("rnd haz_b", 32'(haz_b), 32'(model_haz(in_operandb)));
        check("rnd out_valid", 32'(out_valid), 32'(m_valid));
        check("rnd out_payload",
              32'({out_wr_en, out_opcode, out_operanda, out_operandb, out_dmaddr,
                   out_dest, out_opAdata, out_opBdata}), 32'(m_held));
        check("rnd hist_valid", 32'(hist_valid), 32'(e_hv));
        check("rnd hist_dest", 32'(hist_dest), 32'(e_hd));
        check("rnd hist_opcode", 32'(hist_opcode), 32'(e_ho));
        check("rnd hist_wr_en", 32'(hist_wr_en), 32'(e_hw));
    endtask

    task automatic drive_idle();
        in_valid = 0; in_wr_en = 0; in_opcode = 0; in_operanda = 0; in_operandb = 0;
        in_dmaddr = 0; in_dest = 0; in_opAdata = 0; in_opBdata = 0;
        flush = 0; out_ready = 0;
    endtask

    // ---------------- main ----------------
    initial begin
        //          iv ordy fl wr opc   dest  opa   opb   ad    | rdy ha hb ov opc  ad    hv     hopc
        tbl[0]  = mk(1, 1, 0, 1, 4'h1, 3'd1, 3'd5, 3'd6, 8'h11, 1, 0, 0, 1, 4'h1, 8'h11, 2'b00, 8'h00);
        tbl[1]  = mk(1, 1, 0, 1, 4'h2, 3'd2, 3'd1, 3'd0, 8'h22, 1, 1, 0, 1, 4'h2, 8'h22, 2'b01, 8'h01);
        tbl[2]  = mk(1, 1, 0, 0, 4'h3, 3'd3, 3'd2, 3'd1, 8'h33, 1, 1, 1, 1, 4'h3, 8'h33, 2'b11, 8'h12);
        tbl[3]  = mk(1, 1, 0, 1, 4'h5, 3'd6, 3'd3, 3'd7, 8'hA5, 1, 0, 0, 1, 4'h5, 8'hA5, 2'b11, 8'h23);
        tbl[4]  = mk(1, 0, 0, 0, 4'h9, 3'd0, 3'd6, 3'd2, 8'h00, 0, 1, 1, 1, 4'h5, 8'hA5, 2'b11, 8'h23);
        tbl[5]  = mk(0, 0, 0, 0, 4'h0, 3'd0, 3'd0, 3'd0, 8'h00, 0, 0, 0, 1, 4'h5, 8'hA5, 2'b11, 8'h23);
        tbl[6]  = mk(0, 0, 0, 0, 4'h0, 3'd0, 3'd0, 3'd0, 8'h00, 0, 0, 0, 1, 4'h5, 8'hA5, 2'b11, 8'h23);
        tbl[7]  = mk(0, 1, 0, 0, 4'h0, 3'd0, 3'd0, 3'd0, 8'h00, 1, 0, 0, 0, 4'h5, 8'hA5, 2'b11, 8'h35);
        tbl[8]  = mk(1, 1, 0, 1, 4'h7, 3'd5, 3'd0, 3'd0, 8'h77, 1, 0, 0, 1, 4'h7, 8'h77, 2'b11, 8'h35);
        tbl[9]  = mk(0, 0, 0, 0, 4'h0, 3'd0, 3'd0, 3'd0, 8'h00, 0, 0, 0, 1, 4'h7, 8'h77, 2'b11, 8'h35);
        tbl[10] = mk(1, 0, 1, 0, 4'h8, 3'd0, 3'd5, 3'd6, 8'h88, 0, 1, 1, 0, 4'h7, 8'h77, 2'b11, 8'h35);
        tbl[11] = mk(1, 0, 0, 1, 4'h3, 3'd3, 3'd5, 3'd3, 8'h33, 1, 0, 0, 1, 4'h3, 8'h33, 2'b11, 8'h35);
        tbl[12] = mk(1, 0, 0, 0, 4'h0, 3'd0, 3'd3, 3'd4, 8'h00, 0, 1, 0, 1, 4'h3, 8'h33, 2'b11, 8'h35);
        tbl[13] = mk(1, 1, 1, 0, 4'h0, 3'd0, 3'd6, 3'd0, 8'h00, 0, 1, 0, 0, 4'h3, 8'h33, 2'b11, 8'h53);
        tbl[14] = mk(1, 1, 0, 0, 4'h4, 3'd7, 3'd0, 3'd0, 8'h44, 1, 0, 0, 1, 4'h4, 8'h44, 2'b11, 8'h53);
        tbl[15] = mk(1, 0, 0, 0, 4'h0, 3'd0, 3'd7, 3'd2, 8'h00, 0, 0, 0, 1, 4'h4, 8'h44, 2'b11, 8'h53);

        // reset then idle
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_opcode", 32'(out_opcode), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle out_valid", 32'(out_valid), 32'd0);
        check("idle hist_valid", 32'(hist_valid), 32'd0);
        check("idle hist_opcode", 32'(hist_opcode), 32'd0);
        check("idle in_ready", 32'(in_ready), 32'd1);
        check("idle haz_a", 32'(haz_a), 32'd0);
        @(posedge clk);
        #1;

        // directed table: back-to-back, stall, flush, hazard
        for (int i = 0; i < 16; i++) begin
            in_valid = tbl[i].iv; out_ready = tbl[i].ordy; flush = tbl[i].fl;
            in_wr_en = tbl[i].wr; in_opcode = tbl[i].opc; in_dest = tbl[i].dest;
            in_operanda = tbl[i].opa; in_operandb = tbl[i].opb;
            in_opAdata = tbl[i].ad; in_opBdata = ~tbl[i].ad; in_dmaddr = tbl[i].opc;
            @(negedge clk);
            check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            check($sformatf("vec%0d haz_a", i), 32'(haz_a), 32'(tbl[i].e_ha));
            check($sformatf("vec%0d haz_b", i), 32'(haz_b), 32'(tbl[i].e_hb));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            check($sformatf("vec%0d out_opcode", i), 32'(out_opcode), 32'(tbl[i].e_opc));
            check($sformatf("vec%0d out_opAdata", i), 32'(out_opAdata), 32'(tbl[i].e_ad));
            check($sformatf("vec%0d hist_valid", i), 32'(hist_valid), 32'(tbl[i].e_hv));
            check($sformatf("vec%0d hist_opcode", i), 32'(hist_opcode), 32'(tbl[i].e_hopc));
        end

        // reset mid-stall: state clears before any clock edge
        check("pre-reset out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst hist_valid", 32'(hist_valid), 32'd0);
        check("async rst hist_opcode", 32'(hist_opcode), 32'd0);
        check("async rst out_opcode", 32'(out_opcode), 32'd0);
        drive_idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("post-rst in_ready", 32'(in_ready), 32'd1);
        check("post-rst out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // randomized stimulus against the reference model
        for (int c = 0; c < 400; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 9) == 0);
            in_wr_en    = 1'($urandom_range(0, 1));
            in_opcode   = 4'($urandom_range(0, 15));
            in_operanda = 3'($urandom_range(0, 7));
            in_operandb = 3'($urandom_range(0, 7));
            in_dest     = 3'($urandom_range(0, 7));
            in_dmaddr   = 4'($urandom_range(0, 15));
            in_opAdata  = 8'($urandom_range(0, 255));
            in_opBdata  = 8'($urandom_range(0, 255));
            @(negedge clk);
            model_compare();
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
